// File: rtl/hangman_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hangman_pkg : shared types and default byte codes for the UART scheduler
// Revision    : 1.0
// ---------------------------------------------------------------------------
package hangman_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } tx_sched_state_t;

  localparam logic [7:0] WORD_CODE_DEF = 8'h23;
  localparam logic [7:0] END_CODE_DEF  = 8'h21;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_char_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// char_fifo : synchronous FIFO with push/pop/flush; dout shows the head entry
// Revision  : 1.0
// ---------------------------------------------------------------------------
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_PINC  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   C_CINC  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_DEPTH);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty & ~flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = push & (~full | w_do_pop) & ~flush;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PINC;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PINC;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_CINC;
        2'b01:   r_count <= r_count - C_CINC;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_scheduler : shares the UART transmitter between letters, word-submit
//                     markers and the game-end code, pacing bytes on txready
// Revision          : 1.0
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import hangman_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] WORD_CODE = WORD_CODE_DEF,
  parameter logic [7:0] END_CODE  = END_CODE_DEF,
  parameter int         TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       letter_valid,
  input  logic [7:0] letter_data,
  input  logic       word_submit,
  input  logic       game_end,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       fifo_full,
  output logic [3:0] drop_cnt
);

  localparam int                   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]        C_DEPTH    = CW'(DEPTH);
  localparam logic [3:0]           C_TMO_LAST = 4'(TIMEOUT - 1);

  tx_sched_state_t r_state;
  tx_sched_state_t w_state_nxt;
  logic            r_word_pend;
  logic            r_end_pend;
  logic [3:0]      r_tcnt;
  logic [3:0]      r_drop_cnt;
  logic [7:0]      r_txdata;

  logic            w_launch;
  logic            w_fifo_push;
  logic            w_fifo_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [7:0]      w_fifo_din;
  logic [7:0]      w_fifo_dout;
  logic [CW-1:0]   w_fifo_count;
  logic            w_space;
  logic            w_letter_req;
  logic            w_word_push;
  logic            w_drop;

  // A game_end cycle only flushes; launching waits until end_pend is visible
  assign w_launch     = (r_state == IDLE) & txready & ~game_end &
                        (r_end_pend | ~w_fifo_empty);
  assign w_fifo_pop   = w_launch & ~r_end_pend;
  assign w_space      = ~w_fifo_full | w_fifo_pop;
  assign w_letter_req = letter_valid & ~game_end;
  assign w_word_push  = r_word_pend & ~letter_valid & ~game_end & w_space;
  assign w_fifo_push  = w_letter_req | w_word_push;
  assign w_fifo_din   = letter_valid ? letter_data : WORD_CODE;
  assign w_drop       = w_letter_req & ~w_space;

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .push  (w_fifo_push),
    .pop   (w_fifo_pop),
    .flush (game_end),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_launch) w_state_nxt = LOAD;
      LOAD:      w_state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (!txready)                 w_state_nxt = WAIT_HIGH;
        else if (r_tcnt == C_TMO_LAST) w_state_nxt = IDLE;
      end
      WAIT_HIGH: if (txready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= IDLE;
      r_word_pend <= 1'b0;
      r_end_pend  <= 1'b0;
      r_tcnt      <= '0;
      r_drop_cnt  <= '0;
      r_txdata    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == LOAD)                      r_tcnt <= '0;
      else if (r_state == WAIT_LOW && txready)  r_tcnt <= r_tcnt + 4'd1;

      if (w_launch) r_txdata <= r_end_pend ? END_CODE : w_fifo_dout;

      if (game_end)          r_word_pend <= 1'b0;
      else if (word_submit)  r_word_pend <= 1'b1;
      else if (w_word_push)  r_word_pend <= 1'b0;

      if (game_end)                     r_end_pend <= 1'b1;
      else if (w_launch && r_end_pend)  r_end_pend <= 1'b0;

      if (w_drop && r_drop_cnt != 4'hF) r_drop_cnt <= r_drop_cnt + 4'd1;
    end
  end

  assign txclk     = (r_state == LOAD);
  assign busy      = (r_state != IDLE);
  assign txdata    = r_txdata;
  assign fifo_full = (w_fifo_count == C_DEPTH);
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler : directed self-checking bench for uart_tx_scheduler
// Revision             : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       letter_valid = 1'b0;
  logic [7:0] letter_data = 8'h00;
  logic       word_submit = 1'b0;
  logic       game_end = 1'b0;
  logic       txready = 1'b0;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       fifo_full;
  logic [3:0] drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         c0;
  logic [7:0] tx_q [$];
  int         tx_cyc [$];
  logic       uart_auto = 1'b0;
  int         low_cnt = 0;

  uart_tx_scheduler dut (
    .clk          (clk),
    .nRst         (nRst),
    .letter_valid (letter_valid),
    .letter_data  (letter_data),
    .word_submit  (word_submit),
    .game_end     (game_end),
    .txready      (txready),
    .txdata       (txdata),
    .txclk        (txclk),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Each step lands on a negedge: log any strobe, then run the optional UART model
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (nRst && txclk) begin
        tx_q.push_back(txdata);
        tx_cyc.push_back(cyc);
      end
      if (uart_auto) begin
        if (txclk) low_cnt = 3;
        if (low_cnt > 0) begin
          txready = 1'b0;
          low_cnt--;
        end else begin
          txready = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_log();
    tx_q.delete();
    tx_cyc.delete();
  endtask

  initial begin
    // reset state
    tick(3);
    check_eq("rst_txclk", txclk, 0);
    check_eq("rst_txdata", txdata, 8'h00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_full", fifo_full, 0);
    check_eq("rst_drop", drop_cnt, 0);
    nRst = 1'b1;
    tick(2);

    // single letter latency and busy tracking
    txready = 1'b1;
    letter_valid = 1'b1; letter_data = 8'h41; c0 = cyc;
    tick(1);
    letter_valid = 1'b0;
    check_eq("A_no_early_strobe", txclk, 0);
    tick(1);
    check_eq("A_lat_cycles", cyc - c0, 2);
    check_eq("A_txclk", txclk, 1);
    check_eq("A_txdata", txdata, 8'h41);
    txready = 1'b0;
    tick(1);
    check_eq("A_strobe_one_cycle", txclk, 0);
    tick(2);
    check_eq("A_busy_wait_high", busy, 1);
    txready = 1'b1;
    tick(1);
    check_eq("A_idle_after_ready", busy, 0);
    check_eq("A_txdata_hold", txdata, 8'h41);
    clear_log();

    // letter and word submit in the same cycle
    uart_auto = 1'b1;
    letter_valid = 1'b1; letter_data = 8'h50; word_submit = 1'b1;
    tick(1);
    letter_valid = 1'b0; word_submit = 1'b0;
    tick(30);
    check_eq("B_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check_eq("B_byte0", tx_q[0], 8'h50);
      check_eq("B_byte1", tx_q[1], 8'h23);
    end
    check_eq("B_drops", drop_cnt, 0);
    clear_log();

    // overflow with stalled transmitter
    uart_auto = 1'b0; txready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      letter_valid = 1'b1; letter_data = 8'h61 + 8'(i);
      tick(1);
    end
    letter_valid = 1'b0;
    check_eq("C_full", fifo_full, 1);
    check_eq("C_drops", drop_cnt, 2);
    tick(3);
    check_eq("C_full_hold", fifo_full, 1);
    uart_auto = 1'b1; low_cnt = 0; txready = 1'b1;
    tick(1);
    check_eq("C_full_after_pop", fifo_full, 0);
    tick(40);
    check_eq("C_count", tx_q.size(), 4);
    if (tx_q.size() == 4)
      for (int i = 0; i < 4; i++) check_eq($sformatf("C_byte%0d", i), tx_q[i], 8'h61 + 8'(i));
    check_eq("C_drops_final", drop_cnt, 2);
    clear_log();

    // game end while first byte is in WAIT_HIGH
    uart_auto = 1'b0; txready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      letter_valid = 1'b1; letter_data = 8'h71 + 8'(i);
      tick(1);
    end
    letter_valid = 1'b0; txready = 1'b1;
    tick(1);
    txready = 1'b0;
    tick(2);
    game_end = 1'b1;
    tick(1);
    game_end = 1'b0;
    check_eq("D_busy_inflight", busy, 1);
    uart_auto = 1'b1; low_cnt = 0; txready = 1'b1;
    tick(30);
    check_eq("D_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check_eq("D_byte0", tx_q[0], 8'h71);
      check_eq("D_byte1", tx_q[1], 8'h21);
    end
    clear_log();

    // txready stuck high: WAIT_LOW timeout
    uart_auto = 1'b0; txready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      letter_valid = 1'b1; letter_data = 8'h31 + 8'(i);
      tick(1);
    end
    letter_valid = 1'b0;
    tick(50);
    check_eq("E_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check_eq("E_byte0", tx_q[0], 8'h31);
      check_eq("E_byte1", tx_q[1], 8'h32);
      check_eq("E_gap", tx_cyc[1] - tx_cyc[0], 17);
    end
    check_eq("E_idle", busy, 0);
    clear_log();

    // reset during WAIT_LOW
    for (int i = 0; i < 3; i++) begin
      letter_valid = 1'b1; letter_data = 8'h11 + 8'(i);
      tick(1);
    end
    letter_valid = 1'b0;
    tick(2);
    check_eq("F_busy_pre", busy, 1);
    nRst = 1'b0;
    #1;
    check_eq("F_txclk", txclk, 0);
    check_eq("F_txdata", txdata, 8'h00);
    check_eq("F_busy", busy, 0);
    check_eq("F_drop", drop_cnt, 0);
    check_eq("F_full", fifo_full, 0);
    tick(2);
    nRst = 1'b1;
    clear_log();
    tick(30);
    check_eq("F_no_tx_after", tx_q.size(), 0);
    check_eq("F_idle_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
